// File: rtl/reorder_buffer.sv
// In-order reorder buffer: 2-wide alloc, 3 writeback ports, 2-wide in-order retire.
// Optional ROB_FLUSH_EN adds i_flush, which clears all in-flight state except o_overflow.
package rob_pkg;
  parameter int unsigned RobPtrW = 4;

  typedef struct packed {
    logic               valid;
    logic [RobPtrW-1:0] ROBNumber;
    logic               is_store;
    logic [5:0]         PRegAddrDst;
    logic [5:0]         OldPRegAddrDst;
    logic [31:0]        data;
  } rob_row_struct;
endpackage

module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef ROB_FLUSH_EN
  input  logic             i_flush,
`endif
  input  rob_row_struct    i_rob_rows      [0:1],
  input  rob_row_struct    i_complete_rows [0:2],
  output rob_row_struct    o_retire_rows   [0:1],
  output logic [CNT_W-1:0] o_free_slots,
  output logic             o_full,
  output logic             o_overflow
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] complete_q, complete_d;
  rob_row_struct    row_q [DEPTH];
  rob_row_struct    row_d [DEPTH];
  rob_row_struct    retire_q [2];
  rob_row_struct    retire_d [2];
  logic [PTR_W-1:0] head_q, head_d, head1;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             r0, r1;
  logic [1:0]       n_alloc, n_ret;

  always_comb begin
    valid_d     = valid_q;
    complete_d  = complete_q;
    row_d       = row_q;
    overflow_d  = overflow_q;
    retire_d[0] = '0;
    retire_d[1] = '0;

    // Retire decision looks only at registered state.
    head1 = head_q + PTR_W'(1);
    r0    = valid_q[head_q] & complete_q[head_q];
    r1    = r0 & valid_q[head1] & complete_q[head1];

    if (r0) begin
      retire_d[0]       = row_q[head_q];
      retire_d[0].valid = 1'b1;
      valid_d[head_q]    = 1'b0;
      complete_d[head_q] = 1'b0;
    end
    if (r1) begin
      retire_d[1]       = row_q[head1];
      retire_d[1].valid = 1'b1;
      valid_d[head1]    = 1'b0;
      complete_d[head1] = 1'b0;
    end

    // Ascending port order makes the higher-numbered port win on a collision.
    for (int p = 0; p < 3; p++) begin
      if (i_complete_rows[p].valid && valid_d[i_complete_rows[p].ROBNumber]) begin
        complete_d[i_complete_rows[p].ROBNumber]    = 1'b1;
        row_d[i_complete_rows[p].ROBNumber].data    = i_complete_rows[p].data;
      end
    end

    // Alloc is applied last so it overrides a same-cycle completion of the same index.
    for (int s = 0; s < 2; s++) begin
      if (i_rob_rows[s].valid) begin
        if (valid_d[i_rob_rows[s].ROBNumber]) overflow_d = 1'b1;
        valid_d[i_rob_rows[s].ROBNumber]       = 1'b1;
        complete_d[i_rob_rows[s].ROBNumber]    = 1'b0;
        row_d[i_rob_rows[s].ROBNumber]         = i_rob_rows[s];
        row_d[i_rob_rows[s].ROBNumber].valid   = 1'b1;
        row_d[i_rob_rows[s].ROBNumber].data    = '0;
      end
    end

    n_alloc = {1'b0, i_rob_rows[0].valid} + {1'b0, i_rob_rows[1].valid};
    n_ret   = {1'b0, r0} + {1'b0, r1};
    count_d = count_q + CNT_W'(n_alloc) - CNT_W'(n_ret);
    head_d  = head_q + PTR_W'(n_ret);

`ifdef ROB_FLUSH_EN
    if (i_flush) begin
      valid_d     = '0;
      complete_d  = '0;
      row_d       = row_q;
      overflow_d  = overflow_q;
      head_d      = '0;
      count_d     = '0;
      retire_d[0] = '0;
      retire_d[1] = '0;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q     <= '0;
      complete_q  <= '0;
      head_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      retire_q[0] <= '0;
      retire_q[1] <= '0;
      for (int k = 0; k < DEPTH; k++) row_q[k] <= '0;
    end else begin
      valid_q     <= valid_d;
      complete_q  <= complete_d;
      head_q      <= head_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      retire_q[0] <= retire_d[0];
      retire_q[1] <= retire_d[1];
      for (int k = 0; k < DEPTH; k++) row_q[k] <= row_d[k];
    end
  end

  assign o_retire_rows[0] = retire_q[0];
  assign o_retire_rows[1] = retire_q[1];
  assign o_free_slots     = CNT_W'(DEPTH) - count_q;
  assign o_full           = count_q > CNT_W'(DEPTH - 2);
  assign o_overflow       = overflow_q;

  // Writeback ports only carry index and data; the other fields are don't-care.
  logic unused_cmpl;
  assign unused_cmpl = ^{i_complete_rows[0].is_store, i_complete_rows[0].PRegAddrDst,
                         i_complete_rows[0].OldPRegAddrDst,
                         i_complete_rows[1].is_store, i_complete_rows[1].PRegAddrDst,
                         i_complete_rows[1].OldPRegAddrDst,
                         i_complete_rows[2].is_store, i_complete_rows[2].PRegAddrDst,
                         i_complete_rows[2].OldPRegAddrDst};

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected retire rows, a negedge
// monitor pops and compares every valid retire slot.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          flush;
  rob_row_struct rob_rows      [0:1];
  rob_row_struct complete_rows [0:2];
  rob_row_struct retire_rows   [0:1];
  logic [4:0]    free_slots;
  logic          full;
  logic          overflow;

  int vectors;
  int miscompares;

  typedef struct {
    int slot;
    int rob;
    int dst;
    int old;
    int data;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;

  reorder_buffer #(.DEPTH(16), .PTR_W(4), .CNT_W(5)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
`ifdef ROB_FLUSH_EN
    .i_flush         (flush),
`endif
    .i_rob_rows      (rob_rows),
    .i_complete_rows (complete_rows),
    .o_retire_rows   (retire_rows),
    .o_free_slots    (free_slots),
    .o_full          (full),
    .o_overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every valid retire slot must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && retire_rows[k].valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL retire_unexpected: slot %0d got ROB %0d, expected no retire",
                   k, retire_rows[k].ROBNumber);
        end else begin
          got_e = sb.pop_front();
          if (got_e.slot != k || got_e.rob != int'(retire_rows[k].ROBNumber) ||
              got_e.dst != int'(retire_rows[k].PRegAddrDst) ||
              got_e.old != int'(retire_rows[k].OldPRegAddrDst) ||
              got_e.data != int'(retire_rows[k].data)) begin
            miscompares++;
            $display("FAIL retire_row: got slot %0d rob %0d dst %0d old %0d data %0h, expected slot %0d rob %0d dst %0d old %0d data %0h",
                     k, retire_rows[k].ROBNumber, retire_rows[k].PRegAddrDst,
                     retire_rows[k].OldPRegAddrDst, retire_rows[k].data,
                     got_e.slot, got_e.rob, got_e.dst, got_e.old, got_e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic rob_row_struct mk(input int rob, input int dst, input int old,
                                       input int data);
    rob_row_struct r;
    r                = '0;
    r.valid          = 1'b1;
    r.ROBNumber      = RobPtrW'(rob);
    r.PRegAddrDst    = 6'(dst);
    r.OldPRegAddrDst = 6'(old);
    r.data           = 32'(data);
    return r;
  endfunction

  task automatic expect_retire(input int slot, input int rob, input int dst, input int old,
                               input int data);
    exp_t e;
    e.slot = slot;
    e.rob  = rob;
    e.dst  = dst;
    e.old  = old;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rob_rows[0] = '0;
    rob_rows[1] = '0;
    for (int p = 0; p < 3; p++) complete_rows[p] = '0;
    flush = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    tick();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle_inputs();
    rst_n = 1'b0;

    // Reset state
    tick();
    tick();
    chk("reset_free", int'(free_slots), 16);
    chk("reset_full", int'(full), 0);
    chk("reset_ret0_valid", int'(retire_rows[0].valid), 0);
    chk("reset_ret1_valid", int'(retire_rows[1].valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    rst_n = 1'b1;

    // Basic in-order 2-wide retire
    rob_rows[0] = mk(0, 5, 1, 0);
    rob_rows[1] = mk(1, 6, 2, 0);
    tick();
    idle_inputs();
    chk("alloc2_free", int'(free_slots), 14);
    complete_rows[0] = mk(1, 0, 0, 'h11);
    tick();
    idle_inputs();
    complete_rows[1] = mk(0, 0, 0, 'h10);
    expect_retire(0, 0, 5, 1, 'h10);
    expect_retire(1, 1, 6, 2, 'h11);
    tick();
    idle_inputs();
    tick();
    chk("basic_ret_slot1_valid", int'(retire_rows[1].valid), 1);
    tick();
    chk("basic_ret_pulse", int'(retire_rows[0].valid), 0);
    chk("basic_free_back", int'(free_slots), 16);
    drain("basic_drain");

    // Out-of-order completion; MEM port beats FU0 on the same index
    do_reset();
    rob_rows[0] = mk(0, 7, 3, 0);
    rob_rows[1] = mk(1, 8, 4, 0);
    tick();
    idle_inputs();
    complete_rows[0] = mk(1, 0, 0, 'hAA);
    complete_rows[2] = mk(1, 0, 0, 'h21);
    tick();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("ooo_no_retire", int'(retire_rows[0].valid), 0);
    end
    complete_rows[0] = mk(0, 0, 0, 'h20);
    expect_retire(0, 0, 7, 3, 'h20);
    expect_retire(1, 1, 8, 4, 'h21);
    tick();
    idle_inputs();
    tick();
    chk("ooo_ret_slot0_valid", int'(retire_rows[0].valid), 1);
    drain("ooo_drain");

    // Completion to an invalid entry is ignored; same-cycle alloc beats complete
    do_reset();
    complete_rows[0] = mk(4, 0, 0, 'h55);
    rob_rows[0]      = mk(2, 9, 10, 0);
    complete_rows[1] = mk(2, 0, 0, 'h66);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("alloc_beats_complete", int'(retire_rows[0].valid), 0);
    end
    chk("alloc_beats_free", int'(free_slots), 15);

    // Fill to full, retire everything, then wrap head 15->0
    do_reset();
    for (int i = 0; i < 14; i += 2) begin
      rob_rows[0] = mk(i, 20 + i, 40 + i, 0);
      rob_rows[1] = mk(i + 1, 21 + i, 41 + i, 0);
      tick();
    end
    idle_inputs();
    chk("fill14_full", int'(full), 0);
    chk("fill14_free", int'(free_slots), 2);
    rob_rows[0] = mk(14, 34, 54, 0);
    tick();
    idle_inputs();
    chk("fill15_full", int'(full), 1);
    chk("fill15_free", int'(free_slots), 1);
    rob_rows[0] = mk(15, 35, 55, 0);
    tick();
    idle_inputs();
    chk("fill16_full", int'(full), 1);
    chk("fill16_free", int'(free_slots), 0);
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (c * 3 + p < 16) begin
          complete_rows[p] = mk(c * 3 + p, 0, 0, 'h100 + c * 3 + p);
          expect_retire((c * 3 + p) % 2, c * 3 + p, 20 + c * 3 + p, 40 + c * 3 + p,
                        'h100 + c * 3 + p);
        end
      end
      tick();
      idle_inputs();
    end
    drain("fill_drain");
    chk("fill_free_back", int'(free_slots), 16);
    chk("fill_full_clear", int'(full), 0);
    rob_rows[0] = mk(0, 60, 61, 0);
    rob_rows[1] = mk(1, 62, 63, 0);
    tick();
    idle_inputs();
    complete_rows[2] = mk(0, 0, 0, 'h300);
    complete_rows[1] = mk(1, 0, 0, 'h301);
    expect_retire(0, 0, 60, 61, 'h300);
    expect_retire(1, 1, 62, 63, 'h301);
    tick();
    idle_inputs();
    drain("wrap_drain");
    chk("wrap_free", int'(free_slots), 16);

    // Sticky overflow
    do_reset();
    rob_rows[0] = mk(3, 11, 12, 0);
    tick();
    idle_inputs();
    chk("ovf_before", int'(overflow), 0);
    rob_rows[0] = mk(3, 13, 14, 0);
    tick();
    idle_inputs();
    chk("ovf_set", int'(overflow), 1);
    tick();
    tick();
    chk("ovf_held", int'(overflow), 1);
    do_reset();
    chk("ovf_cleared", int'(overflow), 0);
    chk("ovf_reset_free", int'(free_slots), 16);

`ifdef ROB_FLUSH_EN
    // Flush overrides concurrent alloc and complete
    for (int i = 0; i < 6; i += 2) begin
      rob_rows[0] = mk(i, i, i, 0);
      rob_rows[1] = mk(i + 1, i + 1, i + 1, 0);
      tick();
    end
    idle_inputs();
    chk("flush_pre_free", int'(free_slots), 10);
    flush            = 1'b1;
    rob_rows[0]      = mk(6, 6, 6, 0);
    rob_rows[1]      = mk(7, 7, 7, 0);
    complete_rows[0] = mk(0, 0, 0, 'h1);
    complete_rows[1] = mk(1, 0, 0, 'h2);
    tick();
    idle_inputs();
    chk("flush_free", int'(free_slots), 16);
    tick();
    chk("flush_no_retire", int'(retire_rows[0].valid), 0);
    tick();
    chk("flush_no_retire_late", int'(retire_rows[0].valid), 0);
`endif

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
